rapids_issue_queue: RTL and testbench
=====================================

// Module: rapids_issue_queue
// PURPOSE
//   Parametrised instruction buffer between instruction source and controlpath.
//   Decouples fetch from decode with valid/ready on both sides and a DEPTH-entry FIFO.
//   Tags each instruction with its program counter; supports branch redirect (flush).
//   Replaces the direct instruction wire into controlpath, so the core can stall on multi-cycle ops.
// PARAMETERS
//   INSTR_W   32   instruction width in bits
//   PC_W      32   program counter width
//   DEPTH     4    FIFO entries; power of 2, >= 2
//   PC_STEP   1    PC increment per accepted instruction (word addressing)
//   RESET_PC  0    PC tagged on first instruction after reset
// PORTS
//   clk            in   1              clock; all logic on rising edge
//   reset          in   1              synchronous, active-high
//   in_valid       in   1              upstream instruction valid
//   in_ready       out  1              queue accepts this cycle
//   in_instr       in   INSTR_W        upstream instruction
//   issue_valid    out  1              head entry available to controlpath
//   issue_ready    in   1              controlpath consumes head this cycle
//   issue_instr    out  INSTR_W        head instruction
//   issue_pc       out  PC_W           PC tag of head instruction
//   redirect_valid in   1              branch taken: flush and retarget
//   redirect_pc    in   PC_W           new PC for next accepted instruction
//   count          out  $clog2(DEPTH)+1 current occupancy
// BEHAVIOUR
//   - Reset: count=0, rd/wr pointers=0, pc_next=RESET_PC; in_ready=0, issue_valid=0 during reset cycle.
//   - Push: in_valid&in_ready -> entry {pc_next, in_instr} written at wr_ptr; pc_next += PC_STEP (mod 2^PC_W).
//   - Pop: issue_valid&issue_ready -> rd_ptr advances.
//   - in_ready = !reset & !redirect_valid & (count < DEPTH); no pop-through when full (no comb ready path).
//   - issue_valid = !reset & !redirect_valid & (count != 0); issue_instr/issue_pc = head entry, registered.
//   - Latency: instruction pushed in cycle N is visible at issue in cycle N+1 at earliest; no bypass.
//   - Simultaneous push and pop: count unchanged, both pointers advance.
//   - Stall: while issue_valid & !issue_ready, issue_instr/issue_pc held stable.
//   - Pointers wrap modulo DEPTH; full = count==DEPTH, empty = count==0.
//   - Redirect: highest priority; in that cycle no push, no pop (handshakes ignored);
//     next cycle count=0, pointers=0, pc_next=redirect_pc. Stale entries never issued.
//   - Reset mid-operation: same end state as reset from power-up; queued entries discarded.
//   - Reset and redirect together: reset wins, pc_next=RESET_PC.
//   - No state machine beyond occupancy; modes: EMPTY (count=0), PARTIAL, FULL (count=DEPTH).
// STRUCTURE
//   - rapids_pkg: INSTR_W/PC_W defaults, typedef struct packed {pc, instr} issue_entry_t.
//   - Sub-module rapids_sync_fifo (WIDTH, DEPTH): storage, pointers, count, flush input;
//     rapids_issue_queue adds PC tagging, redirect priority and handshake gating.
// TESTING
//   1. reset, then push 0xA0000001,0xA0000002 with issue_ready=1 -> issued in order, issue_pc=0,1; count returns 0.
//   2. issue_ready=0, push 4 instrs (DEPTH=4) -> count=4, in_ready=0; 5th held upstream; release -> 5 issued, pc 0..4.
//   3. full queue, issue_ready=1 and in_valid=1 same cycle -> pop only that cycle (in_ready=0), push next cycle.
//   4. 3 queued, redirect_valid=1 redirect_pc=0x100 -> that cycle issue_valid=0; next count=0; next push tagged 0x100, then 0x101.
//   5. reset asserted with 2 queued and redirect_valid=1 -> count=0, next push tagged RESET_PC.
//   6. PC_W=4, redirect_pc=0xF, push 2 -> tags 0xF then 0x0 (wrap).

Source files
------------

// File: rtl/rapids_pkg.sv
// Shared defaults and the entry layout for the rapids instruction issue queue.
package rapids_pkg;

    localparam int RAPIDS_INSTR_W = 32;
    localparam int RAPIDS_PC_W    = 32;

    // One queued instruction together with the PC it was fetched from.
    typedef struct packed {
        logic [RAPIDS_PC_W-1:0]    pc;
        logic [RAPIDS_INSTR_W-1:0] instr;
    } issue_entry_t;

endpackage

// File: rtl/rapids_sync_fifo.sv
// Synchronous FIFO: register storage, wrapping pointers, occupancy count and a
// single-cycle flush that empties the queue without touching stored data.
module rapids_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;

    // Next pointer/count state; flush overrides any handshake in the same cycle.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write; data is not reset since stale slots are never read while empty.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/rapids_issue_queue.sv
// Instruction buffer between fetch and controlpath: tags each accepted
// instruction with its PC, gates both handshakes, and flushes on redirect.
module rapids_issue_queue
    import rapids_pkg::*;
#(
    parameter int INSTR_W  = RAPIDS_INSTR_W,
    parameter int PC_W     = RAPIDS_PC_W,
    parameter int DEPTH    = 4,
    parameter int PC_STEP  = 1,
    parameter int RESET_PC = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [INSTR_W-1:0]     in_instr,
    output logic                   issue_valid,
    input  logic                   issue_ready,
    output logic [INSTR_W-1:0]     issue_instr,
    output logic [PC_W-1:0]        issue_pc,
    input  logic                   redirect_valid,
    input  logic [PC_W-1:0]        redirect_pc,
    output logic [$clog2(DEPTH):0] count
);

    // Entry layout sized by this instance's parameters.
    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    localparam int EW = PC_W + INSTR_W;

    logic            full, empty;
    logic            push, pop;
    logic [PC_W-1:0] pc_next_q, pc_next_d;
    entry_t          wentry, rentry;
    logic [EW-1:0]   rdata;

    // Both sides are blocked while resetting or redirecting; ready does not
    // look at issue_ready, so a full queue never accepts a same-cycle refill.
    assign in_ready    = !reset && !redirect_valid && !full;
    assign issue_valid = !reset && !redirect_valid && !empty;
    assign push        = in_valid && in_ready;
    assign pop         = issue_valid && issue_ready;

    assign wentry.pc    = pc_next_q;
    assign wentry.instr = in_instr;

    rapids_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush_i (redirect_valid),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (wentry),
        .rdata_o (rdata),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );

    assign rentry      = entry_t'(rdata);
    assign issue_instr = rentry.instr;
    assign issue_pc    = rentry.pc;

    // Next fetch PC: redirect retargets, each accepted instruction advances it.
    always_comb begin
        pc_next_d = pc_next_q;
        if (redirect_valid) pc_next_d = redirect_pc;
        else if (push)      pc_next_d = pc_next_q + PC_W'(PC_STEP);
    end

    // PC register; reset takes priority over a simultaneous redirect.
    always_ff @(posedge clk) begin
        if (reset) pc_next_q <= PC_W'(RESET_PC);
        else       pc_next_q <= pc_next_d;
    end

endmodule

// File: tb/tb_rapids_issue_queue.sv
// Bench for rapids_issue_queue: directed scenarios plus random traffic,
// checked against a queue-based reference model.
module tb_rapids_issue_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst, in_valid, issue_ready, redir;
    logic [31:0] in_instr, redir_pc;
    logic        in_ready, issue_valid;
    logic [31:0] issue_instr, issue_pc;
    logic [2:0]  count;

    logic        t_rst, t_in_valid, t_issue_ready, t_redir;
    logic [7:0]  t_in_instr, t_issue_instr;
    logic [3:0]  t_redir_pc, t_issue_pc;
    logic        t_in_ready, t_issue_valid;
    logic [2:0]  t_count;

    int checks = 0;
    int errors = 0;

    // Reference model: queued {pc, instr} pairs and the next PC to hand out.
    logic [63:0] mq[$];
    logic [31:0] m_pc;

    always #5 clk = ~clk;

    rapids_issue_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_instr(issue_instr), .issue_pc(issue_pc),
        .redirect_valid(redir), .redirect_pc(redir_pc), .count(count)
    );

    rapids_issue_queue #(.INSTR_W(8), .PC_W(4), .DEPTH(4)) dut_small (
        .clk(clk), .reset(t_rst), .in_valid(t_in_valid), .in_ready(t_in_ready),
        .in_instr(t_in_instr), .issue_valid(t_issue_valid), .issue_ready(t_issue_ready),
        .issue_instr(t_issue_instr), .issue_pc(t_issue_pc),
        .redirect_valid(t_redir), .redirect_pc(t_redir_pc), .count(t_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Check outputs mid-cycle against the model, then advance one clock.
    task automatic cycle();
        logic        exp_rdy, exp_iv, do_push, do_pop;
        logic [63:0] head;
        #1;
        exp_rdy = !rst && !redir && (mq.size() < DEPTH);
        exp_iv  = !rst && !redir && (mq.size() != 0);
        chk("in_ready", 64'(in_ready), 64'(exp_rdy));
        chk("issue_valid", 64'(issue_valid), 64'(exp_iv));
        chk("count", 64'(count), 64'(mq.size()));
        if (exp_iv) begin
            head = mq[0];
            chk("issue_instr", 64'(issue_instr), 64'(head[31:0]));
            chk("issue_pc", 64'(issue_pc), 64'(head[63:32]));
        end
        do_push = in_valid && exp_rdy;
        do_pop  = exp_iv && issue_ready;
        @(posedge clk);
        if (rst) begin
            mq.delete();
            m_pc = 32'd0;
        end else if (redir) begin
            mq.delete();
            m_pc = redir_pc;
        end else begin
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
                mq.push_back({m_pc, in_instr});
                m_pc = m_pc + 32'd1;
            end
        end
        @(negedge clk);
    endtask

    task automatic drive(input logic r, input logic v, input logic [31:0] ins,
                         input logic rdy, input logic rv, input logic [31:0] rpc);
        rst = r; in_valid = v; in_instr = ins; issue_ready = rdy; redir = rv; redir_pc = rpc;
    endtask

    initial begin
        m_pc = 32'd0;
        drive(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        t_rst = 1'b1; t_in_valid = 1'b0; t_in_instr = 8'd0; t_issue_ready = 1'b0;
        t_redir = 1'b0; t_redir_pc = 4'd0;
        @(posedge clk);
        @(negedge clk);

        // Reset cycle itself: both sides blocked, empty.
        cycle();

        // 1: two instructions straight through.
        drive(1'b0, 1'b1, 32'hA000_0001, 1'b1, 1'b0, 32'd0);
        cycle();
        drive(1'b0, 1'b1, 32'hA000_0002, 1'b1, 1'b0, 32'd0);
        cycle();
        drive(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
        cycle();
        cycle();
        chk("drain_count", 64'(count), 64'd0);

        // 2: fill while stalled, fifth held upstream, then release.
        drive(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        cycle();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 32'hB000_0000 + 32'(i), 1'b0, 1'b0, 32'd0);
            cycle();
        end
        #1;
        chk("full_count", 64'(count), 64'd4);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        // 3: pop while full with in_valid high; push lands next cycle.
        drive(1'b0, 1'b1, 32'hB000_0004, 1'b1, 1'b0, 32'd0);
        cycle();
        chk("refill_count", 64'(count), 64'd3);
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, (i == 0), 32'hB000_0004, 1'b1, 1'b0, 32'd0);
            cycle();
        end

        // 4: redirect with three queued.
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 32'hC000_0000 + 32'(i), 1'b0, 1'b0, 32'd0);
            cycle();
        end
        drive(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 32'h100);
        cycle();
        chk("redir_count", 64'(count), 64'd0);
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b1, 32'hD000_0000 + 32'(i), 1'b0, 1'b0, 32'd0);
            cycle();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
            cycle();
        end

        // 5: reset and redirect together with two queued.
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b1, 32'hE000_0000 + 32'(i), 1'b0, 1'b0, 32'd0);
            cycle();
        end
        drive(1'b1, 1'b1, 32'd0, 1'b1, 1'b1, 32'h200);
        cycle();
        drive(1'b0, 1'b1, 32'hE000_00FF, 1'b1, 1'b0, 32'd0);
        cycle();
        drive(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
        cycle();
        cycle();

        // Random traffic with occasional redirect and reset.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 65), $urandom(),
                  ($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 4), $urandom());
            cycle();
        end

        // 6: PC wrap on a 4-bit PC instance.
        t_rst = 1'b0; t_redir = 1'b1; t_redir_pc = 4'hF;
        @(posedge clk); @(negedge clk);
        t_redir = 1'b0; t_in_valid = 1'b1; t_in_instr = 8'h11;
        @(posedge clk); @(negedge clk);
        t_in_instr = 8'h22;
        @(posedge clk); @(negedge clk);
        t_in_valid = 1'b0; t_issue_ready = 1'b1;
        #1;
        chk("wrap_count", 64'(t_count), 64'd2);
        chk("wrap_pc0", 64'(t_issue_pc), 64'hF);
        chk("wrap_instr0", 64'(t_issue_instr), 64'h11);
        @(posedge clk); @(negedge clk);
        #1;
        chk("wrap_pc1", 64'(t_issue_pc), 64'h0);
        chk("wrap_instr1", 64'(t_issue_instr), 64'h22);
        @(posedge clk); @(negedge clk);
        #1;
        chk("wrap_empty", 64'(t_issue_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
